// File: rtl/reaction_ms_counter.sv
// Millisecond BCD stopwatch for the reaction timer: times each start_clock window,
// latches the trial result and keeps the fastest non-saturated time since reset/clear.
module reaction_ms_counter #(
    parameter int DIV  = 50000,
    parameter int PS_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_clock,
    input  logic        clear,
    output logic [15:0] result_bcd,
    output logic [15:0] best_bcd,
    output logic        result_valid,
    output logic        overflow,
    output logic        running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(DIV - 1);
    localparam logic [15:0]     BCD_MAX  = 16'h9999;

    state_t          r_state, w_state_n;
    logic [PS_W-1:0] r_ps, w_ps_n;
    logic [15:0]     r_count, w_count_n;
    logic [15:0]     r_result, w_result_n;
    logic [15:0]     r_best, w_best_n;
    logic            r_valid, w_valid_n;
    logic            r_ovf, w_ovf_n;
    logic            r_start_d;
    logic            w_rise, w_fall;
    logic [15:0]     w_inc;

    // Four-digit BCD increment; the caller guarantees the input is below 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign w_rise = start_clock & ~r_start_d;
    assign w_fall = ~start_clock & r_start_d;
    assign w_inc  = bcd_inc(r_count);

    always_comb begin
        w_state_n  = r_state;
        w_ps_n     = r_ps;
        w_count_n  = r_count;
        w_result_n = r_result;
        w_best_n   = r_best;
        w_valid_n  = r_valid;
        w_ovf_n    = r_ovf;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_n = COUNT;
                    w_ps_n    = '0;
                    w_count_n = '0;
                    w_ovf_n   = 1'b0;
                end
            end
            COUNT: begin
                if (w_fall) begin
                    w_state_n  = HOLD;
                    w_result_n = r_count;
                    w_valid_n  = 1'b1;
                    // Digit-packed BCD orders the same as plain binary.
                    if (!r_ovf && (r_count < r_best)) begin
                        w_best_n = r_count;
                    end
                end else if (r_ps == PS_LAST) begin
                    w_ps_n = '0;
                    if (r_count != BCD_MAX) begin
                        w_count_n = w_inc;
                        if (w_inc == BCD_MAX) begin
                            w_ovf_n = 1'b1;
                        end
                    end
                end else begin
                    w_ps_n = r_ps + PS_W'(1);
                end
            end
            HOLD: begin
                if (w_rise) begin
                    w_state_n = COUNT;
                    w_valid_n = 1'b0;
                    w_ps_n    = '0;
                    w_count_n = '0;
                    w_ovf_n   = 1'b0;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        // Clear wins over everything, but a simultaneous rise still launches a fresh trial.
        if (clear) begin
            w_result_n = '0;
            w_best_n   = BCD_MAX;
            w_valid_n  = 1'b0;
            w_ovf_n    = 1'b0;
            w_state_n  = IDLE;
            if (w_rise) begin
                w_state_n = COUNT;
                w_ps_n    = '0;
                w_count_n = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // Tracking start_clock through reset keeps a level held across release from looking like a rise.
        r_start_d <= start_clock;
        if (reset) begin
            r_state  <= IDLE;
            r_ps     <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_best   <= BCD_MAX;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_ps     <= w_ps_n;
            r_count  <= w_count_n;
            r_result <= w_result_n;
            r_best   <= w_best_n;
            r_valid  <= w_valid_n;
            r_ovf    <= w_ovf_n;
        end
    end

    assign result_bcd   = r_result;
    assign best_bcd     = r_best;
    assign result_valid = r_valid;
    assign overflow     = r_ovf;
    assign running      = (r_state == COUNT);

endmodule

// File: tb/tb_reaction_ms_counter.sv
// Scoreboard bench for reaction_ms_counter: one instance with DIV=4, one with DIV=2.
module tb_reaction_ms_counter;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] best;
        logic        ov;
    } exp_t;

    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  start;
    logic [1:0]  clr;
    logic [15:0] res  [2];
    logic [15:0] best [2];
    logic [1:0]  vld;
    logic [1:0]  ovf;
    logic [1:0]  run;

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    reaction_ms_counter #(.DIV(4), .PS_W(16)) u4 (
        .clk(clk), .reset(rst[0]), .start_clock(start[0]), .clear(clr[0]),
        .result_bcd(res[0]), .best_bcd(best[0]), .result_valid(vld[0]),
        .overflow(ovf[0]), .running(run[0])
    );

    reaction_ms_counter #(.DIV(2), .PS_W(16)) u2 (
        .clk(clk), .reset(rst[1]), .start_clock(start[1]), .clear(clr[1]),
        .result_bcd(res[1]), .best_bcd(best[1]), .result_valid(vld[1]),
        .overflow(ovf[1]), .running(run[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pops an expected record on every rising edge of result_valid.
    task automatic mon(input int u);
        logic pv;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (vld[u] === 1'b1 && pv !== 1'b1) begin
                if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL u%0d_unexpected_result: got result %h, none expected", u, res[u]);
                end else begin
                    e = (u == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("u%0d_result", u), {16'h0, res[u]},  {16'h0, e.res});
                    check($sformatf("u%0d_best", u),   {16'h0, best[u]}, {16'h0, e.best});
                    check($sformatf("u%0d_overflow", u), {31'h0, ovf[u]}, {31'h0, e.ov});
                end
            end
            pv = vld[u];
        end
    endtask

    task automatic trial(input int u, input int h, input logic [15:0] er,
                         input logic [15:0] eb, input logic eo);
        exp_t e;
        e.res  = er;
        e.best = eb;
        e.ov   = eo;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(negedge clk);
        start[u] = 1'b1;
        repeat (h) @(negedge clk);
        start[u] = 1'b0;
        @(negedge clk);
        check($sformatf("u%0d_valid_latency_h%0d", u, h), {31'h0, vld[u]}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr(input int u);
        @(negedge clk);
        clr[u] = 1'b1;
        @(negedge clk);
        clr[u] = 1'b0;
    endtask

    task automatic check_reset_vals(input int u, input string tag);
        check({tag, "_result"}, {16'h0, res[u]},  32'h0);
        check({tag, "_best"},   {16'h0, best[u]}, 32'h9999);
        check({tag, "_valid"},  {31'h0, vld[u]},  32'd0);
        check({tag, "_ovf"},    {31'h0, ovf[u]},  32'd0);
        check({tag, "_run"},    {31'h0, run[u]},  32'd0);
    endtask

    initial begin
        start = 2'b00;
        clr   = 2'b00;
        rst   = 2'b11;
        fork
            mon(0);
            mon(1);
        join_none
        repeat (3) @(negedge clk);
        rst = 2'b00;
        @(negedge clk);
        check_reset_vals(0, "u4_reset");
        check_reset_vals(1, "u2_reset");

        // Basic trial: 12 counting cycles / 4 = 3 ms
        trial(0, 13, 16'h0003, 16'h0003, 1'b0);

        pulse_clr(0);
        check_reset_vals(0, "u4_clear_hold");

        // Best tracking across trials
        trial(0, 41, 16'h0010, 16'h0010, 1'b0);
        trial(0, 21, 16'h0005, 16'h0005, 1'b0);
        trial(0, 33, 16'h0008, 16'h0005, 1'b0);

        // Clear mid-count aborts the trial
        @(negedge clk);
        start[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("u4_running_mid", {31'h0, run[0]}, 32'd1);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check_reset_vals(0, "u4_clear_count");
        repeat (5) @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("u4_no_result_after_clear", {31'h0, vld[0]}, 32'd0);

        // start_clock held high through reset release
        rst[0]   = 1'b1;
        start[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("u4_no_count_held_high", {31'h0, run[0]}, 32'd0);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("u4_no_result_held_high", {31'h0, vld[0]}, 32'd0);

        // Reset during COUNT
        trial(0, 13, 16'h0003, 16'h0003, 1'b0);
        @(negedge clk);
        start[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("u4_running_before_reset", {31'h0, run[0]}, 32'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check_reset_vals(0, "u4_reset_mid_count");
        repeat (5) @(negedge clk);
        check("u4_idle_after_reset", {31'h0, run[0]}, 32'd0);
        start[0] = 1'b0;

        // DIV=2: saturation, then digit carry
        trial(1, 20003, 16'h9999, 16'h9999, 1'b1);
        trial(1, 200,   16'h0099, 16'h0099, 1'b0);
        trial(1, 201,   16'h0100, 16'h0099, 1'b0);

        repeat (5) @(negedge clk);
        check("u4_queue_drained", q0.size(), 32'd0);
        check("u2_queue_drained", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
